axi_rd_responder: RTL and testbench

//  AXI4 read-channel responder (slave) backed by an internal word-addressed memory array.

---
 rtl/axi_rd_responder.sv | 197 +++++++++++++++++++
 tb/tb_axi_rd_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder backed by a word-addressed 64-bit memory.
// One outstanding burst, programmable AR-to-RVALID latency, side-port loader.
module axi_rd_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RD_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  ARID,
  input  logic [63:0] ARADDR,
  input  logic [7:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  input  logic [2:0]  ARPORT,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [3:0]  RID,
  output logic [63:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic        mem_we,
  input  logic [63:0] mem_waddr,
  input  logic [63:0] mem_wdata
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_e;

  state_e      state_q, state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic        rlast_q, rlast_d;
  logic [3:0]  rid_q, rid_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [3:0]  id_q, id_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  beat_q, beat_d;
  logic [3:0]  lat_q, lat_d;

  logic [63:0] mem [DEPTH_WORDS];

  logic [63:0] step, wmask, next_addr, beat_addr, roff, ridx, woff, widx;
  logic        slverr, decerr, wr_ok;
  logic [63:0] beat_data;
  logic [1:0]  beat_resp;
  logic        unused_bits;

  assign unused_bits = ^ARPORT;

  // Beat address generation and per-beat response/data lookup
  always_comb begin
    step  = 64'd1 << size_q;
    // (len+1)*S - 1 without a multiplier: len<<size fills the bits above S-1
    wmask = (64'(len_q) << size_q) | (step - 64'd1);
    case (burst_q)
      2'b01:   next_addr = (addr_q & ~(step - 64'd1)) + step;
      2'b10:   next_addr = (addr_q & ~wmask) | ((addr_q + step) & wmask);
      default: next_addr = addr_q;
    endcase
    beat_addr = (state_q == S_BEAT) ? next_addr : addr_q;

    slverr = (size_q > 3'd3) || (burst_q == 2'b11) ||
             ((burst_q == 2'b10) && !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15}));
    roff   = beat_addr - BASE_ADDR;
    ridx   = roff >> 3;
    decerr = (beat_addr < BASE_ADDR) || (ridx >= 64'(DEPTH_WORDS));

    beat_data = '0;
    beat_resp = 2'b00;
    if (slverr)      beat_resp = 2'b10;
    else if (decerr) beat_resp = 2'b11;
    else             beat_data = mem[ridx[AW-1:0]];
  end

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    case (state_q)
      S_IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          id_d      = ARID;
          addr_d    = ARADDR;
          len_d     = ARLEN;
          size_d    = ARSIZE;
          burst_d   = ARBURST;
          beat_d    = '0;
          lat_d     = 4'(RD_LATENCY - 1);
          arready_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == 4'd0) begin
          rid_d    = id_q;
          rdata_d  = beat_data;
          rresp_d  = beat_resp;
          rlast_d  = (len_q == 8'd0);
          rvalid_d = 1'b1;
          state_d  = S_BEAT;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_BEAT: begin
        if (RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            addr_d  = next_addr;
            beat_d  = beat_q + 8'd1;
            rdata_d = beat_data;
            rresp_d = beat_resp;
            rlast_d = ((beat_q + 8'd1) == len_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
    end
  end

  // Loader port; a same-edge beat load still sees the pre-write word
  always_comb begin
    woff  = mem_waddr - BASE_ADDR;
    widx  = woff >> 3;
    wr_ok = mem_we && (mem_waddr >= BASE_ADDR) && (widx < 64'(DEPTH_WORDS));
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[widx[AW-1:0]] <= mem_wdata;
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder: latency, burst types, errors, backpressure, reset.
module tb_axi_rd_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  ARID = '0;
  logic [63:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic [2:0]  ARPORT = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b1;
  logic        mem_we = 1'b0;
  logic [63:0] mem_waddr = '0;
  logic [63:0] mem_wdata = '0;

  int unsigned tests = 0;
  int unsigned errors = 0;
  logic [63:0] w [8];

  axi_rd_responder #(
    .BASE_ADDR   (64'h8000_0000),
    .DEPTH_WORDS (4096),
    .RD_LATENCY  (2)
  ) dut (
    .clk(clk), .rstn(rstn),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARPORT(ARPORT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [63:0] a, input logic [63:0] d);
    mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
    tick();
    mem_we = 1'b0;
  endtask

  // Returns one cycle after the AR handshake edge
  task automatic ar_req(input logic [3:0] id, input logic [63:0] a, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int unsigned n = 0;
    ARID = id; ARADDR = a; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    while (!ARREADY && n < 40) begin tick(); n++; end
    if (!ARREADY) check_eq("ar_timeout", 64'(ARREADY), 64'd1);
    tick();
    ARVALID = 1'b0;
  endtask

  task automatic recv_beat(input string tag, input logic [63:0] ed, input logic [1:0] er,
                           input logic el, input logic [3:0] eid, input bit stall);
    int unsigned n = 0;
    while (!RVALID && n < 30) begin tick(); n++; end
    check_eq({tag, ".valid"}, 64'(RVALID), 64'd1);
    if (stall) begin
      RREADY = 1'b0;
      tick();
      check_eq({tag, ".hold_valid"}, 64'(RVALID), 64'd1);
      check_eq({tag, ".hold_data"}, RDATA, ed);
      RREADY = 1'b1;
    end
    check_eq({tag, ".data"}, RDATA, ed);
    check_eq({tag, ".resp"}, 64'(RRESP), 64'(er));
    check_eq({tag, ".last"}, 64'(RLAST), 64'(el));
    check_eq({tag, ".id"}, 64'(RID), 64'(eid));
    tick();
  endtask

  initial begin
    w[0] = 64'h1122_3344_5566_7788;
    for (int i = 1; i < 8; i++) w[i] = 64'hC0DE_0000_0000_0000 | 64'(i * 17);

    // Reset state
    #12;
    check_eq("rst.arready", 64'(ARREADY), 64'd0);
    check_eq("rst.rvalid", 64'(RVALID), 64'd0);
    check_eq("rst.rdata", RDATA, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_eq("rst.arready_pre_edge", 64'(ARREADY), 64'd0);
    tick();
    check_eq("rst.arready_rise", 64'(ARREADY), 64'd1);

    for (int i = 0; i < 8; i++) mem_write(64'h8000_0000 + 64'(i * 8), w[i]);

    // 1: single beat, latency 2
    ar_req(4'd0, 64'h8000_0000, 8'd0, 3'd2, 2'b01);
    check_eq("t1.lat_e0", 64'(RVALID), 64'd0);
    tick();
    check_eq("t1.lat_e1", 64'(RVALID), 64'd0);
    tick();
    check_eq("t1.lat_e2", 64'(RVALID), 64'd1);
    recv_beat("t1", w[0], 2'b00, 1'b1, 4'd0, 1'b0);
    check_eq("t1.rvalid_drop", 64'(RVALID), 64'd0);

    // 2: INCR with stalls on every beat
    ar_req(4'd1, 64'h8000_0008, 8'd3, 3'd3, 2'b01);
    recv_beat("t2.b0", w[1], 2'b00, 1'b0, 4'd1, 1'b1);
    recv_beat("t2.b1", w[2], 2'b00, 1'b0, 4'd1, 1'b1);
    recv_beat("t2.b2", w[3], 2'b00, 1'b0, 4'd1, 1'b1);
    recv_beat("t2.b3", w[4], 2'b00, 1'b1, 4'd1, 1'b1);

    // 3: WRAP 4x8 from word 2, then illegal WRAP length
    ar_req(4'd2, 64'h8000_0010, 8'd3, 3'd3, 2'b10);
    recv_beat("t3.b0", w[2], 2'b00, 1'b0, 4'd2, 1'b0);
    recv_beat("t3.b1", w[3], 2'b00, 1'b0, 4'd2, 1'b0);
    recv_beat("t3.b2", w[0], 2'b00, 1'b0, 4'd2, 1'b0);
    recv_beat("t3.b3", w[1], 2'b00, 1'b1, 4'd2, 1'b0);
    ar_req(4'd3, 64'h8000_0010, 8'd2, 3'd3, 2'b10);
    recv_beat("t3w.b0", 64'd0, 2'b10, 1'b0, 4'd3, 1'b0);
    recv_beat("t3w.b1", 64'd0, 2'b10, 1'b0, 4'd3, 1'b0);
    recv_beat("t3w.b2", 64'd0, 2'b10, 1'b1, 4'd3, 1'b0);

    // Narrow INCR (aligns then steps by 4) and FIXED
    ar_req(4'd4, 64'h8000_0004, 8'd2, 3'd2, 2'b01);
    recv_beat("tn.b0", w[0], 2'b00, 1'b0, 4'd4, 1'b0);
    recv_beat("tn.b1", w[1], 2'b00, 1'b0, 4'd4, 1'b0);
    recv_beat("tn.b2", w[1], 2'b00, 1'b1, 4'd4, 1'b0);
    ar_req(4'd5, 64'h8000_0018, 8'd1, 3'd3, 2'b00);
    recv_beat("tf.b0", w[3], 2'b00, 1'b0, 4'd5, 1'b0);
    recv_beat("tf.b1", w[3], 2'b00, 1'b1, 4'd5, 1'b1);

    // 4: decode errors below base and past the end
    ar_req(4'd6, 64'h7FFF_FFF8, 8'd1, 3'd3, 2'b00);
    recv_beat("t4lo.b0", 64'd0, 2'b11, 1'b0, 4'd6, 1'b0);
    recv_beat("t4lo.b1", 64'd0, 2'b11, 1'b1, 4'd6, 1'b0);
    check_eq("t4lo.arready", 64'(ARREADY), 64'd1);
    ar_req(4'd7, 64'h8000_8000, 8'd1, 3'd3, 2'b01);
    recv_beat("t4hi.b0", 64'd0, 2'b11, 1'b0, 4'd7, 1'b0);
    recv_beat("t4hi.b1", 64'd0, 2'b11, 1'b1, 4'd7, 1'b0);
    check_eq("t4hi.arready", 64'(ARREADY), 64'd1);

    // Loader write colliding with a beat load returns the old word
    ar_req(4'd8, 64'h8000_0028, 8'd0, 3'd3, 2'b01);
    tick();
    mem_we = 1'b1; mem_waddr = 64'h8000_0028; mem_wdata = 64'hDEAD_BEEF_0000_0005;
    tick();
    mem_we = 1'b0;
    check_eq("tc.old_data", RDATA, w[5]);
    tick();
    w[5] = 64'hDEAD_BEEF_0000_0005;
    ar_req(4'd9, 64'h8000_0028, 8'd0, 3'd3, 2'b01);
    recv_beat("tc.new", w[5], 2'b00, 1'b1, 4'd9, 1'b0);

    // 5: second AR held during the first burst
    ar_req(4'd10, 64'h8000_0000, 8'd1, 3'd3, 2'b01);
    ARID = 4'd11; ARADDR = 64'h8000_0038; ARLEN = 8'd0; ARSIZE = 3'd3; ARBURST = 2'b01;
    ARVALID = 1'b1;
    check_eq("t5.arready_busy0", 64'(ARREADY), 64'd0);
    recv_beat("t5.a0", w[0], 2'b00, 1'b0, 4'd10, 1'b0);
    check_eq("t5.arready_busy1", 64'(ARREADY), 64'd0);
    recv_beat("t5.a1", w[1], 2'b00, 1'b1, 4'd10, 1'b1);
    check_eq("t5.arready_free", 64'(ARREADY), 64'd1);
    ar_req(4'd11, 64'h8000_0038, 8'd0, 3'd3, 2'b01);
    recv_beat("t5.b0", w[7], 2'b00, 1'b1, 4'd11, 1'b0);

    // 6: async reset mid-burst
    ar_req(4'd12, 64'h8000_0000, 8'd3, 3'd3, 2'b01);
    recv_beat("t6.b0", w[0], 2'b00, 1'b0, 4'd12, 1'b0);
    check_eq("t6.b1_valid", 64'(RVALID), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check_eq("t6.rvalid_async", 64'(RVALID), 64'd0);
    check_eq("t6.arready_async", 64'(ARREADY), 64'd0);
    check_eq("t6.rdata_async", RDATA, 64'd0);
    tick();
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_eq("t6.arready_pre", 64'(ARREADY), 64'd0);
    tick();
    check_eq("t6.arready_rise", 64'(ARREADY), 64'd1);
    ar_req(4'd13, 64'h8000_0008, 8'd1, 3'd3, 2'b01);
    recv_beat("t6.m0", w[1], 2'b00, 1'b0, 4'd13, 1'b0);
    recv_beat("t6.m1", w[2], 2'b00, 1'b1, 4'd13, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
